regfile_read_pipe: RTL
======================

// Module: regfile_read_pipe
// PURPOSE
//  Register-file storage with two registered read ports and one write port, for the 32-bit RISC datapath.
//  The write side accepts data from writeback, using the same D/enable style as a single 32-bit register.
//  The read side feeds operand fetch: rs1/rs2 values are returned one cycle after a request, with a valid flag.
//  Operand-fetch stalls freeze the read outputs.
// PARAMETERS
//  WIDTH  32  data width of each register and each read/write port
//  DEPTH  32  number of architectural registers; entry 0 is hard-wired to zero
//  AW      5  address width; must equal clog2(DEPTH)
// PORTS
//  clk       input   1      system clock; all state updates on the rising edge
//  reset     input   1      synchronous, active-high reset
//  wr_en     input   1      write strobe
//  wr_addr   input   AW     write register index
//  wr_data   input   WIDTH  write data
//  rd_req    input   1      read request; samples rs1_addr/rs2_addr
//  rs1_addr  input   AW     read port 1 register index
//  rs2_addr  input   AW     read port 2 register index
//  stall     input   1      freeze read outputs; the request in this cycle is not taken
//  rs1_data  output  WIDTH  registered read data, port 1
//  rs2_data  output  WIDTH  registered read data, port 2
//  rd_valid  output  1      rs1_data/rs2_data hold the result of a taken request
// BEHAVIOUR
//  - Reset (synchronous, highest priority):
//    - all DEPTH entries cleared to 0; rs1_data=0, rs2_data=0, rd_valid=0.
//    - wr_en and rd_req are ignored in the reset cycle.
//    - a request taken in the cycle before reset deasserts is lost, and rd_valid reads 0.
//  - Write: at a rising edge with wr_en=1, reset=0 and wr_addr!=0, mem[wr_addr]<=wr_data.
//    - wr_addr==0 writes are discarded.
//    - wr_addr>=DEPTH is discarded.
//    - stall does not block writes.
//  - Read: 1-cycle latency. At a rising edge with reset=0:
//    - stall=1: rs1_data, rs2_data and rd_valid hold their values; rd_req is dropped, so the requester re-presents it.
//    - stall=0, rd_req=1: rsN_data <= rd_val(rsN_addr), rd_valid <= 1.
//    - stall=0, rd_req=0: rd_valid <= 0; rs1_data/rs2_data hold (no bus toggling).
//  - rd_val(a):
//    - 0 if a==0 or a>=DEPTH.
//    - otherwise, see CONFIGURATION for a same-edge write to the same address.
//    - otherwise mem[a] as it stood before the edge.
//  - Same address on both read ports: both ports return the same value.
//  - Back-to-back requests: one result per cycle, no bubbles while stall=0.
//  - No state machine beyond the array and the output register stage; rd_valid is the only control flop.
// CONFIGURATION
//  Macro REGFILE_BYPASS_EN:
//  - Defined: write-to-read forwarding. If wr_en=1, wr_addr!=0 and wr_addr==rsN_addr at the same edge as a taken
//    request, rsN_data gets wr_data (the new value).
//  - Undefined: no forwarding. That read returns the pre-write mem contents; the new value is visible to requests
//    taken on later edges. The pipeline must then insert one bubble for a writeback->fetch hazard.
// TESTING
//  1 Reset: hold reset=1 for 2 clks with wr_en=1 (addr 3, 'hDEADBEEF) and rd_req=1
//    -> rs1_data=0, rs2_data=0, rd_valid=0. A later read of r3 returns 0.
//  2 Write/read: write r5='h6FFFFFFF and r9='h0088140A; then rd_req with rs1=5, rs2=9
//    -> next edge rs1_data='h6FFFFFFF, rs2_data='h0088140A, rd_valid=1.
//    -> the following cycle with rd_req=0 gives rd_valid=0 and data held.
//  3 r0: write r0='hAAAAAA88; read rs1=0, rs2=0 -> both 0. A read of r31 after writing 'h12345678 -> 'h12345678.
//  4 Same-edge hazard: r7='h11111111, then in one cycle write r7='h33333333 and request rs1=7
//    -> 'h33333333 with REGFILE_BYPASS_EN, 'h11111111 without it.
//    -> the next request returns 'h33333333 in both builds.
//  5 Stall: a taken read returns r5='h6FFFFFFF. Then raise stall for 3 clks with rd_req=1, rs1=9, and write r5='hC0C0C0C0
//    -> outputs frozen at 'h6FFFFFFF, rd_valid=1.
//    -> after stall drops, the next edge gives rs1_data='h0088140A.
//    -> a later read of r5 gives 'hC0C0C0C0.
//  6 Reset mid-stream: continuous rd_req with reset pulsed for 1 clk
//    -> rd_valid=0 and data 0 for that edge.
//    -> valid resumes on the next edge; all registers read 0.

Source files
------------

// File: rtl/regfile_read_pipe.sv
// Register file with one write port and two registered read ports with a shared valid flag.
// Optional macro REGFILE_BYPASS_EN forwards a same-edge write to a taken read of the same address.
module regfile_read_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_req,
   input  logic [AW-1:0]    rs1_addr,
   input  logic [AW-1:0]    rs2_addr,
   input  logic             stall,
   output logic [WIDTH-1:0] rs1_data,
   output logic [WIDTH-1:0] rs2_data,
   output logic             rd_valid
);

   logic [WIDTH-1:0] mem [DEPTH];

   logic             wr_hit;
   logic             rd_take;
   logic [AW-1:0]    rd_addr [2];
   logic [WIDTH-1:0] rd_next [2];

   // Entry 0 is never written, so it stays at its reset value of zero.
   assign wr_hit  = wr_en && (wr_addr != '0) && (32'(wr_addr) < DEPTH);
   assign rd_take = rd_req && !stall;

   assign rd_addr[0] = rs1_addr;
   assign rd_addr[1] = rs2_addr;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_next[p] = '0;
         if ((rd_addr[p] != '0) && (32'(rd_addr[p]) < DEPTH)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && (wr_addr == rd_addr[p])) begin
               rd_next[p] = wr_data;
            end else begin
               rd_next[p] = mem[rd_addr[p]];
            end
`else
            rd_next[p] = mem[rd_addr[p]];
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rs1_data <= '0;
         rs2_data <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (wr_hit) begin
            mem[wr_addr] <= wr_data;
         end
         // A stall freezes the whole output stage; without one, data only moves on a request.
         if (!stall) begin
            rd_valid <= rd_req;
         end
         if (rd_take) begin
            rs1_data <= rd_next[0];
            rs2_data <= rd_next[1];
         end
      end
   end

endmodule
